// File: rtl/hpc2_and_pipe.sv
// hpc2_and_pipe: order-D HPC2 masked AND gadget with a valid-tracking pipeline.
//   N = D+1 Boolean shares per operand, NR = D*(D+1)/2 fresh random bits per operation.
//   c = a & b is produced as N output shares two cycles after the operands are sampled.
//   Optional macro HPC2_AND_OUT_REG_EN adds a registered output bank (latency 3), which
//   makes every output share glitch-free at the module boundary.
// Register placement keeps shares separated. The only cross-share signal formed before a
// register is V_ij = b_j ^ r_ij, and it is registered immediately. Every term is kept in
// its own per-share or per-pair flop so that synthesis cannot merge logic across share
// boundaries.

module hpc2_and_pipe #(
  parameter int D = 1
) (
  input  logic                   clock_0,
  input  logic                   reset_0,
  input  logic                   in_valid,
  input  logic [D:0]             io_i0,
  input  logic [D:0]             io_i1,
  input  logic [D*(D+1)/2-1:0]   p_rand,
  output logic [D:0]             io_o0,
  output logic                   out_valid
);

  localparam int N  = D + 1;
  localparam int NR = D * (D + 1) / 2;

  // Index of the random bit shared by the unordered pair (i, j), i != j.
  function automatic int pair_idx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * N - lo * (lo + 1) / 2 + (hi - lo - 1);
  endfunction

  // Stage-1 per-share registers.
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_na;
  logic [NR-1:0] r_rnd;
  // Stage-2 per-share registers.
  logic [N-1:0]  r_ab;
  // Valid chain: bit 0 follows stage 1, bit 1 follows stage 2.
  logic [1:0]    r_vld;

  // Per-pair contribution U_ij ^ AV_ij; the diagonal is tied to zero.
  logic [N-1:0][N-1:0] w_term;
  logic [N-1:0]        w_c;

  // Stage 1: capture operand shares, inverted a shares and the randomness every cycle.
  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      r_a   <= '0;
      r_b   <= '0;
      r_na  <= '0;
      r_rnd <= '0;
    end else begin
      r_a   <= io_i0;
      r_b   <= io_i1;
      r_na  <= ~io_i0;
      r_rnd <= p_rand;
    end
  end

  // Stage 2: the same-share product a_i & b_i.
  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      r_ab <= '0;
    end else begin
      r_ab <= r_a & r_b;
    end
  end

  // Valid tracking. Invalid cycles still move data, but they never raise out_valid.
  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[0], in_valid};
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      if (gi != gj) begin : g_pair
        localparam int K = pair_idx(gi, gj);
        logic r_v;
        logic r_u;
        logic r_av;

        // Stage 1: remask share b_j with r_ij before it can meet share a_i.
        always_ff @(posedge clock_0 or negedge reset_0) begin
          if (!reset_0) begin
            r_v <= 1'b0;
          end else begin
            r_v <= io_i1[gj] ^ p_rand[K];
          end
        end

        // Stage 2: ~a_i & r_ij and a_i & (b_j ^ r_ij), kept in separate flops.
        always_ff @(posedge clock_0 or negedge reset_0) begin
          if (!reset_0) begin
            r_u  <= 1'b0;
            r_av <= 1'b0;
          end else begin
            r_u  <= r_na[gi] & r_rnd[K];
            r_av <= r_a[gi] & r_v;
          end
        end

        assign w_term[gi][gj] = r_u ^ r_av;
      end else begin : g_diag
        assign w_term[gi][gj] = 1'b0;
      end
    end
  end

  // Output shares: a purely combinational XOR tree on the stage-2 flops of row i.
  always_comb begin
    w_c = r_ab;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_c[i] = w_c[i] ^ w_term[i][j];
      end
    end
  end

`ifdef HPC2_AND_OUT_REG_EN
  logic [N-1:0] r_o;
  logic         r_ovld;

  // Output bank: every share leaves the gadget directly from a flop.
  always_ff @(posedge clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      r_o    <= '0;
      r_ovld <= 1'b0;
    end else begin
      r_o    <= w_c;
      r_ovld <= r_vld[1];
    end
  end

  assign io_o0     = r_o;
  assign out_valid = r_ovld;
`else
  assign io_o0     = w_c;
  assign out_valid = r_vld[1];
`endif

endmodule

// File: tb/tb_hpc2_and_pipe.sv
// Directed bench for hpc2_and_pipe, with instances at D=1, D=2 and D=3.
module tb_hpc2_and_pipe;

`ifdef HPC2_AND_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       v1, ov1;
  logic [1:0] a1, b1, o1;
  logic [0:0] p1;

  logic       v2, ov2;
  logic [2:0] a2, b2, p2, o2;

  logic       v3, ov3;
  logic [3:0] a3, b3, o3;
  logic [5:0] p3;

  hpc2_and_pipe #(.D(1)) u_d1 (
    .clock_0(clk), .reset_0(rst_n), .in_valid(v1), .io_i0(a1), .io_i1(b1),
    .p_rand(p1), .io_o0(o1), .out_valid(ov1));

  hpc2_and_pipe #(.D(2)) u_d2 (
    .clock_0(clk), .reset_0(rst_n), .in_valid(v2), .io_i0(a2), .io_i1(b2),
    .p_rand(p2), .io_o0(o2), .out_valid(ov2));

  hpc2_and_pipe #(.D(3)) u_d3 (
    .clock_0(clk), .reset_0(rst_n), .in_valid(v3), .io_i0(a3), .io_i1(b3),
    .p_rand(p3), .io_o0(o3), .out_valid(ov3));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // D=1 expected-value pipeline. Index 0 holds the most recently retired drive.
  logic       q_v  [LAT];
  logic [1:0] q_c  [LAT];
  logic       q_ab [LAT];
  logic       last_v;
  logic [1:0] last_c;
  logic       last_ab;

  // One D=1 cycle: check the output due now, then drive the next operation.
  task automatic step1(input logic v, input logic [1:0] a, input logic [1:0] b, input logic r);
    logic [1:0] c;
    @(negedge clk);
    for (int i = LAT - 1; i > 0; i--) begin
      q_v[i]  = q_v[i-1];
      q_c[i]  = q_c[i-1];
      q_ab[i] = q_ab[i-1];
    end
    q_v[0]  = last_v;
    q_c[0]  = last_c;
    q_ab[0] = last_ab;
    check("d1_out_valid", 32'(ov1), 32'(q_v[LAT-1]));
    if (q_v[LAT-1]) begin
      check("d1_shares", 32'(o1), 32'(q_c[LAT-1]));
      check("d1_unmasked", 32'(o1[0] ^ o1[1]), 32'(q_ab[LAT-1]));
    end
    c[0] = (a[0] & b[0]) ^ r ^ (a[0] & b[1]);
    c[1] = (a[1] & b[1]) ^ r ^ (a[1] & b[0]);
    v1 = v; a1 = a; b1 = b; p1 = r;
    last_v  = v;
    last_c  = c;
    last_ab = (a[0] ^ a[1]) & (b[0] ^ b[1]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_o1"}, 32'(o1), 32'h0);
    check({tag, "_ov1"}, 32'(ov1), 32'h0);
    check({tag, "_o2"}, 32'(o2), 32'h0);
    check({tag, "_ov2"}, 32'(ov2), 32'h0);
    check({tag, "_o3"}, 32'(o3), 32'h0);
    check({tag, "_ov3"}, 32'(ov3), 32'h0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    v1 = 1'b0;
    last_v = 1'b0;
    for (int i = 0; i < LAT; i++) q_v[i] = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] x;
    logic [3:0] first;
    logic       varied;

    rst_n = 1'b1;
    v1 = 0; a1 = 0; b1 = 0; p1 = 0;
    v2 = 0; a2 = 0; b2 = 0; p2 = 0;
    v3 = 0; a3 = 0; b3 = 0; p3 = 0;
    last_v = 0; last_c = 0; last_ab = 0;
    for (int i = 0; i < LAT; i++) begin
      q_v[i] = 0; q_c[i] = 0; q_ab[i] = 0;
    end
    first = 0;
    varied = 0;

    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // D=1 exhaustive: a shares, b shares and r, all valid and back to back.
    for (int n = 0; n < 32; n++) begin
      x = n[4:0];
      step1(1'b1, x[1:0], x[3:2], x[4]);
    end
    repeat (LAT + 1) step1(1'b0, 2'b00, 2'b00, 1'b0);

    // in_valid 1,0,1,1 followed by idle cycles.
    step1(1'b1, 2'b01, 2'b11, 1'b1);
    step1(1'b0, 2'b11, 2'b11, 1'b0);
    step1(1'b1, 2'b10, 2'b01, 1'b0);
    step1(1'b1, 2'b11, 2'b11, 1'b1);
    repeat (LAT + 1) step1(1'b0, 2'b00, 2'b00, 1'b0);

    // Reset one cycle after a valid input: that operation must never come out.
    step1(1'b1, 2'b01, 2'b10, 1'b0);
    pulse_reset();
    repeat (LAT + 2) step1(1'b0, 2'b00, 2'b00, 1'b0);

    // D=2 directed vectors, back to back.
    @(negedge clk);
    v2 = 1; a2 = 3'b101; b2 = 3'b011; p2 = 3'b110;
    @(negedge clk);
    a2 = 3'b100; b2 = 3'b010;
    @(negedge clk);
    v2 = 0; a2 = 0; b2 = 0; p2 = 0;
    repeat (LAT - 2) @(negedge clk);
    check("d2_v0_valid", 32'(ov2), 32'h1);
    check("d2_v0_shares", 32'(o2), 32'h3);
    check("d2_v0_unmasked", 32'(^o2), 32'h0);
    @(negedge clk);
    check("d2_v1_valid", 32'(ov2), 32'h1);
    check("d2_v1_shares", 32'(o2), 32'h7);
    check("d2_v1_unmasked", 32'(^o2), 32'h1);
    @(negedge clk);
    check("d2_idle_valid", 32'(ov2), 32'h0);

    // D=3 randomness sensitivity: a=b=1 with 64 fresh p_rand values.
    for (int n = 0; n < 64 + LAT; n++) begin
      @(negedge clk);
      if (n >= LAT) begin
        check("d3_valid", 32'(ov3), 32'h1);
        check("d3_unmasked", 32'(^o3), 32'h1);
        if (n == LAT) first = o3;
        else if (o3 != first) varied = 1'b1;
      end
      if (n < 64) begin
        v3 = 1; a3 = 4'b0001; b3 = 4'b0111; p3 = 6'($urandom);
      end else begin
        v3 = 0;
      end
    end
    check("d3_shares_vary", 32'(varied), 32'h1);
    @(negedge clk);
    check("d3_idle_valid", 32'(ov3), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hpc2_and_pipe.md
# hpc2_and_pipe

Parametrised HPC2 masked AND gadget for order `D`, with `D+1` Boolean shares per operand and `D(D+1)/2` fresh random bits per operation. It is the successor of the fixed first-order HPC2 AND and adds three things: a generic order, a valid-tracking pipeline, and an optional output register stage. It sits in masked datapaths (S-box cores) as the non-linear primitive. Composability under the combined glitch/transition random-probing model is preserved by the register placement below.

## Interface
Parameters:
- `D`, default 1: masking order; `N = D+1` shares. Legal range 1..7.
- `NR`, derived as `D*(D+1)/2`: number of fresh random bits. Not overridable.

Ports:
- `clock_0`  in  1: the only clock; all registers are rising-edge.
- `reset_0`  in  1: reset, asynchronous and active-low; clears every register.
- `in_valid`  in  1: qualifies `io_i0`, `io_i1` and `p_rand` in the current cycle.
- `io_i0`  in  N: shares of operand a; bit i is share i.
- `io_i1`  in  N: shares of operand b.
- `p_rand`  in  NR: fresh randomness; must be new and uniform on every valid cycle.
- `io_o0`  out  N: shares of c = a & b.
- `out_valid`  out  1: `io_o0` holds the result of a valid operation.

## Operation
- Pair index for i<j: k(i,j) = i*N − i*(i+1)/2 + (j−i−1). Set r_ij = r_ji = p_rand[k].
- Stage 1 registers, loaded every cycle regardless of `in_valid`:
  - A_i = a_i
  - B_i = b_i
  - NA_i = ~a_i
  - R_k = r_k
  - V_ij = b_j ^ r_ij, for all i≠j
- Stage 2 registers, loaded every cycle:
  - AB_i = A_i & B_i
  - U_ij = NA_i & R_ij
  - AV_ij = A_i & V_ij
- Output: c_i = AB_i ^ XOR over j≠i of (U_ij ^ AV_ij).
  - This XOR tree is purely combinational on stage-2 registers.
  - No signal may mix share i with share j before a register, except through V_ij.
- Correctness: XOR of all c_i equals (XOR of a_i) & (XOR of b_i) for any `p_rand`.
- Valid pipeline: `in_valid` shifts through a 2-bit register chain to drive `out_valid`.
  - Invalid cycles still advance the data registers; the outputs of those cycles are don't-care.
- Back-to-back valid operations are fully pipelined, one per cycle. There is no stall and no ready signal.
- Synthesis must keep the structure: per-share registers and no logic optimisation across share boundaries.

## Timing
- Latency: 2 cycles from an `in_valid` sample to `out_valid`/`io_o0` (3 with the macro).
- Throughput: 1 operation per cycle.
- `p_rand` is consumed in the same cycle as the operands.
- Reset values:
  - All data registers are 0, so `io_o0` = 0.
  - `out_valid` = 0.
- Reset asserted mid-operation: all in-flight operations are dropped. `out_valid` stays 0 until 2 (or 3) cycles after the first valid cycle following deassertion.
- Reset deassertion is used asynchronously at the flop. The integrator synchronises the release externally.

## Configuration
- `HPC2_AND_OUT_REG_EN`:
  - Defined: an extra register bank on `io_o0` and `out_valid` (reset to 0). Latency becomes 3 cycles. Each output share is glitch-free at the boundary.
  - Undefined: outputs are driven directly by the combinational XOR tree. Latency is 2 cycles.

## Test plan
- D=1, exhaustive over all 2^5 combinations of a, b shares and r, with `in_valid`=1 -> `io_o0[0]^io_o0[1]` = a&b two cycles later in every case.
- D=2, a shares=3'b101 (a=0), b shares=3'b011 (b=0), p_rand=3'b110 -> XOR of output shares = 0. Repeat with a=3'b100 (a=1), b=3'b010 (b=1) -> XOR of output shares = 1.
- `in_valid` pattern 1,0,1,1 -> `out_valid` pattern 0,0,1,0,1,1 (without macro). Results match the respective inputs.
- Reset pulse asserted one cycle after a valid input -> `out_valid` never rises for that input. `io_o0`=0 while in reset.
- Build with `HPC2_AND_OUT_REG_EN`, same D=1 stimulus -> `out_valid` and correct result 3 cycles after input.
- Randomness sensitivity, D=3, fixed a=b=1 across 64 random `p_rand` values -> unmasked output always 1, while individual output shares vary.
